// File: rtl/r_rom_bridge.sv
// r_rom_bridge: TileLink-UL Get slave that fetches ROM data over byte-wide command/response FIFOs
// Ports: clk, rst_n (async, active-low)
//        A channel: i_a_valid, o_a_ready, i_a_opcode, i_a_address, i_a_size, i_a_source
//        D channel: o_d_valid, i_d_ready, o_d_opcode, o_d_data, o_d_size, o_d_source, o_d_denied
//        command FIFO: i_full, o_wr_en, o_din
//        response FIFO: i_empty, o_rd_en, i_dout (valid the cycle after o_rd_en)
module r_rom_bridge #(
   parameter int unsigned ADDR_BYTES = 4,
   parameter int unsigned DATA_BYTES = 8,
   parameter logic [7:0]  CMD_BYTE   = 8'h03,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned SRC_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_a_valid,
   output logic                    o_a_ready,
   input  logic [2:0]              i_a_opcode,
   input  logic [8*ADDR_BYTES-1:0] i_a_address,
   input  logic [2:0]              i_a_size,
   input  logic [SRC_W-1:0]        i_a_source,
   output logic                    o_d_valid,
   input  logic                    i_d_ready,
   output logic [2:0]              o_d_opcode,
   output logic [63:0]             o_d_data,
   output logic [2:0]              o_d_size,
   output logic [SRC_W-1:0]        o_d_source,
   output logic                    o_d_denied,
   input  logic                    i_full,
   output logic                    o_wr_en,
   output logic [7:0]              o_din,
   input  logic                    i_empty,
   output logic                    o_rd_en,
   input  logic [7:0]              i_dout
);
   localparam logic [2:0] TL_GET = 3'd4;
   localparam logic [2:0] TL_ACCESS_ACK = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
   localparam int CW = $clog2(8) + 1;
   localparam logic [CW-1:0] AB_LAST = CW'(ADDR_BYTES - 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DATA_BYTES - 1);
   localparam logic [CW-1:0] DB_NUM = CW'(DATA_BYTES);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_RESP} state_t;

   state_t                    r_state, w_next;
   logic [8*ADDR_BYTES-1:0]   r_addr_buf;
   logic [CW-1:0]             r_addr_cnt, r_rd_cnt, r_byte_cnt;
   logic [15:0]               r_tmo;
   logic [63:0]               r_data_buf;
   logic [2:0]                r_size;
   logic [SRC_W-1:0]          r_source;
   logic                      r_is_get, r_err, r_cap;
   logic                      w_accept, w_is_get, w_tmo_hit, w_rd;

   assign o_a_ready = rst_n & (r_state == S_IDLE);
   assign w_accept = i_a_valid & o_a_ready;
   assign w_is_get = i_a_opcode == TL_GET;
   // r_cap marks a byte landing on i_dout this cycle from a read issued in S_DATA
   assign w_tmo_hit = ~r_cap & (r_tmo == TMO_LAST);
   // reads outside S_DATA are stale-byte drains whose data is discarded
   assign o_rd_en = rst_n & w_rd;
   assign o_d_valid = r_state == S_RESP;
   assign o_d_opcode = r_is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
   assign o_d_data = r_data_buf;
   assign o_d_size = r_size;
   assign o_d_source = r_source;
   assign o_d_denied = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      o_wr_en = 1'b0;
      o_din = 8'h00;
      w_rd = ~i_empty;
      case (r_state)
         S_IDLE: w_next = w_accept ? (w_is_get ? S_CMD : S_RESP) : S_IDLE;
         S_CMD: begin
            o_wr_en = ~i_full;
            o_din = CMD_BYTE;
            w_next = i_full ? S_CMD : S_ADDR;
         end
         S_ADDR: begin
            o_wr_en = ~i_full;
            o_din = r_addr_buf[7:0];
            w_next = (~i_full & (r_addr_cnt == AB_LAST)) ? S_DATA : S_ADDR;
         end
         S_DATA: begin
            w_rd = ~i_empty & (r_rd_cnt != DB_NUM);
            w_next = ((r_cap & (r_byte_cnt == DB_LAST)) | w_tmo_hit) ? S_RESP : S_DATA;
         end
         S_RESP: begin
            w_rd = 1'b0;
            w_next = i_d_ready ? S_IDLE : S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_buf <= '0;
         r_addr_cnt <= '0;
         r_rd_cnt <= '0;
         r_byte_cnt <= '0;
         r_tmo <= '0;
         r_data_buf <= '0;
         r_size <= '0;
         r_source <= '0;
         r_is_get <= 1'b0;
         r_err <= 1'b0;
         r_cap <= 1'b0;
      end else begin
         r_cap <= (r_state == S_DATA) & w_rd;
         if (w_accept) begin
            r_addr_buf <= i_a_address;
            r_size <= i_a_size;
            r_source <= i_a_source;
            r_is_get <= w_is_get;
            r_err <= ~w_is_get;
            r_addr_cnt <= '0;
            r_rd_cnt <= '0;
            r_byte_cnt <= '0;
            r_tmo <= '0;
            r_data_buf <= '0;
         end
         if (r_state == S_ADDR && !i_full) begin
            r_addr_buf <= r_addr_buf >> 8;
            r_addr_cnt <= r_addr_cnt + 1'b1;
         end
         if (r_state == S_DATA) begin
            if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (r_cap) begin
               r_data_buf[{r_byte_cnt[2:0], 3'b000} +: 8] <= i_dout;
               r_byte_cnt <= r_byte_cnt + 1'b1;
               r_tmo <= '0;
            end else begin
               r_tmo <= (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;
            end
            // a timed-out beat is denied and carries no partial data
            if (w_tmo_hit) begin
               r_err <= 1'b1;
               r_data_buf <= '0;
            end
         end
         if (r_state == S_RESP && i_d_ready) r_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_r_rom_bridge.sv
// tb_r_rom_bridge: randomized and directed bench for r_rom_bridge with an in-bench transaction model
module tb_r_rom_bridge;
   localparam int AB = 4;
   localparam int DB = 8;
   localparam int TMO = 1024;
   localparam logic [2:0] GET = 3'd4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- main instance (default parameters) ----------------
   logic        rst_n = 1'b0, a_valid = 1'b0, d_ready = 1'b0, full = 1'b0;
   logic [2:0]  a_opcode = 3'd0, a_size = 3'd0;
   logic [31:0] a_address = 32'd0;
   logic [3:0]  a_source = 4'd0;
   logic        a_ready, d_valid, d_denied, wr_en, rd_en, empty;
   logic [2:0]  d_opcode, d_size;
   logic [63:0] d_data;
   logic [3:0]  d_source;
   logic [7:0]  din;
   logic [7:0]  dout = 8'h00;

   r_rom_bridge u0 (
      .clk(clk), .rst_n(rst_n),
      .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_opcode(a_opcode), .i_a_address(a_address),
      .i_a_size(a_size), .i_a_source(a_source),
      .o_d_valid(d_valid), .i_d_ready(d_ready), .o_d_opcode(d_opcode), .o_d_data(d_data),
      .o_d_size(d_size), .o_d_source(d_source), .o_d_denied(d_denied),
      .i_full(full), .o_wr_en(wr_en), .o_din(din),
      .i_empty(empty), .o_rd_en(rd_en), .i_dout(dout)
   );

   // response FIFO contents: written by stimulus, popped by the FIFO model
   logic [7:0] rsp_mem [2048];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign empty = wr_ptr == rd_ptr;

   logic [7:0] cmd_log[$];
   int   wr_idx = 0;
   logic busy = 1'b0;

   always @(posedge clk) begin
      if (wr_en && !full) begin
         cmd_log.push_back(din);
         wr_idx <= wr_idx + 1;
      end
      if (rd_en && !empty) begin
         dout <= rsp_mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
      if (a_valid && a_ready) begin
         busy <= 1'b1;
         wr_idx <= 0;
      end
      if (d_valid && d_ready) busy <= 1'b0;
   end

   // model of the transaction in flight
   logic        chk_en = 1'b0;
   logic [7:0]  exp_cmd [9];
   int          n_cmd = 0;
   logic [2:0]  exp_op = 3'd0, exp_size = 3'd0;
   logic [3:0]  exp_src = 4'd0;
   logic [63:0] exp_data = 64'd0;
   logic        exp_den = 1'b0;

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("a_ready", 64'(a_ready), 64'(!busy));
         chk("wr_en_when_full", 64'(wr_en & full), 64'(0));
         chk("rd_en_when_empty", 64'(rd_en & empty), 64'(0));
         chk("d_valid_unexpected", 64'(d_valid & ~busy), 64'(0));
         if (wr_en) begin
            if (wr_idx < n_cmd) chk("din", 64'(din), 64'(exp_cmd[wr_idx]));
            else chk("extra_write", 64'(wr_idx), 64'(n_cmd - 1));
         end
         if (d_valid) begin
            chk("d_opcode", 64'(d_opcode), 64'(exp_op));
            chk("d_denied", 64'(d_denied), 64'(exp_den));
            chk("d_data", d_data, exp_data);
            chk("d_size", 64'(d_size), 64'(exp_size));
            chk("d_source", 64'(d_source), 64'(exp_src));
         end
      end
   end

   task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] sz,
                          input logic [3:0] src, input logic [63:0] data, input bit starve,
                          input int full_at, input int full_len, input bit rnd, input int hold,
                          output int lat, output int lastw, output int nwr, output logic [63:0] got);
      int cyc = 0;
      int pushed = 0;
      int guard = 0;
      lastw = -1;
      exp_cmd[0] = 8'h03;
      for (int i = 0; i < AB; i++) exp_cmd[i+1] = addr[8*i +: 8];
      n_cmd = (op == GET) ? AB + 1 : 0;
      exp_op = (op == GET) ? 3'd1 : 3'd0;
      exp_den = (op != GET) || starve;
      exp_data = exp_den ? 64'd0 : data;
      exp_size = sz;
      exp_src = src;
      while (!a_ready && guard < 100) begin
         tick();
         guard++;
      end
      a_opcode = op;
      a_address = addr;
      a_size = sz;
      a_source = src;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      while (!d_valid && cyc < 3000) begin
         if (lastw < 0 && n_cmd > 0 && wr_idx == n_cmd) lastw = cyc;
         full = rnd ? ($urandom_range(0, 2) == 0) : (cyc >= full_at && cyc < full_at + full_len);
         if (lastw >= 0 && !starve && pushed < DB && (!rnd || $urandom_range(0, 3) != 0)) begin
            rsp_mem[wr_ptr] = data[8*pushed +: 8];
            wr_ptr++;
            pushed++;
         end
         tick();
         cyc++;
      end
      full = 1'b0;
      chk("d_valid_arrives", 64'(d_valid), 64'(1));
      lat = cyc + 1;
      got = d_data;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("d_valid_held", 64'(d_valid), 64'(1));
      end
      d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
      nwr = wr_idx;
   endtask

   // ---------------- sweep instance: ADDR_BYTES=2, DATA_BYTES=4 ----------------
   logic        rst1_n = 1'b0, av1 = 1'b0, dr1 = 1'b0, empty1 = 1'b1;
   logic        full1 = 1'b0;
   logic [2:0]  op1 = 3'd0, sz1 = 3'd0;
   logic [15:0] addr1 = 16'd0;
   logic [3:0]  src1 = 4'd0;
   logic        ar1, dv1, dden1, wr1, rd1;
   logic [2:0]  dop1, dsz1;
   logic [63:0] dd1;
   logic [3:0]  dsrc1;
   logic [7:0]  din1;
   logic [7:0]  dout1 = 8'h00;
   logic [7:0]  ctr1 = 8'hA0;
   logic [7:0]  log1[$];

   r_rom_bridge #(.ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT(16)) u1 (
      .clk(clk), .rst_n(rst1_n),
      .i_a_valid(av1), .o_a_ready(ar1), .i_a_opcode(op1), .i_a_address(addr1),
      .i_a_size(sz1), .i_a_source(src1),
      .o_d_valid(dv1), .i_d_ready(dr1), .o_d_opcode(dop1), .o_d_data(dd1),
      .o_d_size(dsz1), .o_d_source(dsrc1), .o_d_denied(dden1),
      .i_full(full1), .o_wr_en(wr1), .o_din(din1),
      .i_empty(empty1), .o_rd_en(rd1), .i_dout(dout1)
   );

   always @(posedge clk) begin
      if (wr1 && !full1) log1.push_back(din1);
      if (rd1 && !empty1) begin
         dout1 <= ctr1;
         ctr1 <= ctr1 + 8'd1;
      end
   end

   task automatic get1(input logic [15:0] addr, input bit do_reset, output logic [63:0] got, output int lat);
      int cyc = 0;
      int base = log1.size();
      got = 64'd0;
      chk("u1_a_ready_before", 64'(ar1), 64'(1));
      op1 = GET;
      addr1 = addr;
      sz1 = 3'd2;
      src1 = 4'd9;
      av1 = 1'b1;
      tick();
      av1 = 1'b0;
      while (log1.size() - base < 3 && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("u1_cmd_count", 64'(log1.size() - base), 64'(3));
      if (do_reset) begin
         tick();
         tick();
         empty1 = 1'b0;
         rst1_n = 1'b0;
         #1;
         chk("u1_rst_a_ready", 64'(ar1), 64'(0));
         chk("u1_rst_d_valid", 64'(dv1), 64'(0));
         chk("u1_rst_d_denied", 64'(dden1), 64'(0));
         chk("u1_rst_d_data", dd1, 64'(0));
         chk("u1_rst_wr_en", 64'(wr1), 64'(0));
         chk("u1_rst_din", 64'(din1), 64'(0));
         chk("u1_rst_rd_en", 64'(rd1), 64'(0));
         tick();
         empty1 = 1'b1;
         rst1_n = 1'b1;
         tick();
         lat = 0;
      end else begin
         empty1 = 1'b0;
         while (!dv1 && cyc < 200) begin
            tick();
            cyc++;
         end
         empty1 = 1'b1;
         chk("u1_d_valid", 64'(dv1), 64'(1));
         chk("u1_d_denied", 64'(dden1), 64'(0));
         chk("u1_d_opcode", 64'(dop1), 64'(1));
         chk("u1_d_source", 64'(dsrc1), 64'(9));
         lat = cyc + 1;
         got = dd1;
         dr1 = 1'b1;
         tick();
         dr1 = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat, lastw, nwr, base;
      logic [63:0] got;
      rsp_mem[0] = 8'h5A;
      wr_ptr = 1;
      repeat (3) tick();
      chk("rst_a_ready", 64'(a_ready), 64'(0));
      chk("rst_d_valid", 64'(d_valid), 64'(0));
      chk("rst_d_denied", 64'(d_denied), 64'(0));
      chk("rst_d_data", d_data, 64'(0));
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_din", 64'(din), 64'(0));
      chk("rst_rd_en", 64'(rd_en), 64'(0));
      rst_n = 1'b1;
      rst1_n = 1'b1;
      tick();
      tick();
      chk("stale_drained_after_reset", 64'(empty), 64'(1));
      chk_en = 1'b1;

      base = cmd_log.size();
      run_txn(GET, 32'h8000_1234, 3'd3, 4'd5, 64'h1817161514131211, 0, 0, 0, 0, 0, lat, lastw, nwr, got);
      chk("t1_data", got, 64'h1817161514131211);
      chk("t1_latency", 64'(lat), 64'(15));
      chk("t1_nwr", 64'(nwr), 64'(5));
      chk("t1_b0", 64'(cmd_log[base]), 64'h03);
      chk("t1_b1", 64'(cmd_log[base+1]), 64'h34);
      chk("t1_b2", 64'(cmd_log[base+2]), 64'h12);
      chk("t1_b3", 64'(cmd_log[base+3]), 64'h00);
      chk("t1_b4", 64'(cmd_log[base+4]), 64'h80);

      base = cmd_log.size();
      run_txn(GET, 32'hCAFE_0A5B, 3'd2, 4'd1, 64'h0123456789ABCDEF, 0, 2, 5, 0, 0, lat, lastw, nwr, got);
      chk("bp_nwr", 64'(nwr), 64'(5));
      chk("bp_latency", 64'(lat), 64'(20));
      chk("bp_b1", 64'(cmd_log[base+1]), 64'h5B);
      chk("bp_b4", 64'(cmd_log[base+4]), 64'hCA);

      run_txn(GET, 32'h0000_0100, 3'd3, 4'd7, 64'h1122334455667788, 1, 0, 0, 0, 0, lat, lastw, nwr, got);
      chk("tmo_cycles_in_data", 64'(lat - 1 - lastw), 64'(TMO));
      chk("tmo_data", got, 64'd0);
      for (int i = 0; i < 3; i++) begin
         rsp_mem[wr_ptr] = 8'hE0 + 8'(i);
         wr_ptr++;
      end
      repeat (5) tick();
      chk("late_bytes_drained", 64'(empty), 64'(1));

      run_txn(GET, 32'h1357_9BDF, 3'd1, 4'd3, 64'hFEDCBA9876543210, 0, 0, 0, 0, 10, lat, lastw, nwr, got);
      chk("hold_a_ready_after", 64'(a_ready), 64'(1));

      run_txn(3'd0, 32'h2222_3333, 3'd2, 4'd4, 64'h0, 0, 0, 0, 0, 0, lat, lastw, nwr, got);
      chk("put_latency", 64'(lat), 64'(1));
      chk("put_nwr", 64'(nwr), 64'(0));

      for (int t = 0; t < 40; t++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : GET;
         run_txn(op, $urandom, 3'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, 0, 0, 0, 1, $urandom_range(0, 3), lat, lastw, nwr, got);
         chk("rand_nwr", 64'(nwr), 64'((op == GET) ? AB + 1 : 0));
      end

      base = log1.size();
      get1(16'hBEEF, 0, got, lat);
      chk("u1_b0", 64'(log1[base]), 64'h03);
      chk("u1_b1", 64'(log1[base+1]), 64'hEF);
      chk("u1_b2", 64'(log1[base+2]), 64'hBE);
      chk("u1_data", got, 64'h0000_0000_A3A2_A1A0);
      chk("u1_latency", 64'(lat), 64'(9));
      get1(16'h1234, 1, got, lat);
      get1(16'h4321, 0, got, lat);
      chk("u1_data_after_reset", got, 64'h0000_0000_A7A6_A5A4);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
